// File: rtl/core_run_controller_pkg.sv
// core_run_controller_pkg: shared FSM state encoding and default widths for the run controller.
package core_run_controller_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_DONE} state_e;
  localparam int IMEM_AW_DEF = 6;
  localparam int CYC_W_DEF = 16;
  localparam int TIMEOUT_DEF = 1000;
  localparam int RST_CYC_DEF = 2;
endpackage

// File: rtl/core_run_controller_run_cycle_timer.sv
// run_cycle_timer: saturating clear/enable cycle counter with terminal-count flag at TIMEOUT-1.
module run_cycle_timer
  import core_run_controller_pkg::*;
#(
  parameter int CYC_W = CYC_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CYC_W-1:0] count,
  output logic             tc
);
  logic [CYC_W-1:0] count_q, count_d;
  always_comb count_d = clr ? '0 : (en && count_q != '1) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count_q <= '0;
    else count_q <= count_d;
  assign count = count_q;
  assign tc = count_q == CYC_W'(TIMEOUT - 1);
endmodule

// File: rtl/core_run_controller.sv
// core_run_controller: loads a program into imem, holds the core in reset, runs it and times it out.
module core_run_controller
  import core_run_controller_pkg::*;
#(
  parameter int IMEM_AW = IMEM_AW_DEF,
  parameter int CYC_W = CYC_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int RST_CYC = RST_CYC_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [IMEM_AW-1:0] prog_len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  output logic               imem_we,
  output logic [IMEM_AW+1:0] imem_addr,
  output logic [31:0]        imem_wdata,
  output logic               core_rst_n,
  output logic [IMEM_AW-1:0] no_instruct,
  input  logic               eof,
  output logic               busy,
  output logic               done,
  output logic               timeout,
  output logic [CYC_W-1:0]   cycle_count
);
  localparam int HW = $clog2(RST_CYC) + 1;
  state_e state_q, state_d;
  logic [IMEM_AW-1:0] len_q, len_d, idx_q, idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic timeout_q, timeout_d, we_q, we_d, clr, tc, beat;
  logic [IMEM_AW+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  assign beat = state_q == S_LOAD && in_valid;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    idx_d = idx_q;
    hold_d = hold_q;
    timeout_d = timeout_q;
    clr = 1'b0;
    case (state_q)
      S_IDLE: if (start && prog_len != '0) begin
        len_d = prog_len;
        idx_d = '0;
        clr = 1'b1;
        timeout_d = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: if (in_valid) begin
        idx_d = idx_q + 1'b1;
        hold_d = '0;
        state_d = idx_q == len_q - 1'b1 ? S_HOLD : S_LOAD;
      end
      S_HOLD: begin
        hold_d = hold_q + 1'b1;
        state_d = hold_q == HW'(RST_CYC - 1) ? S_RUN : S_HOLD;
      end
      S_RUN: if (eof) state_d = S_DONE;
        else if (tc) begin
          timeout_d = 1'b1;
          state_d = S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end
  // The write port is registered so each accepted beat lands one cycle later, even across abort.
  always_comb begin
    we_d = beat;
    addr_d = beat ? {idx_q, 2'b00} : addr_q;
    wdata_d = beat ? in_data : wdata_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q <= '0;
      idx_q <= '0;
      hold_q <= '0;
      timeout_q <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      idx_q <= idx_d;
      hold_q <= hold_d;
      timeout_q <= timeout_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
    end
  run_cycle_timer #(.CYC_W(CYC_W), .TIMEOUT(TIMEOUT)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .clr(clr),
    .en(state_q == S_RUN),
    .count(cycle_count),
    .tc(tc)
  );
  assign in_ready = state_q == S_LOAD;
  assign core_rst_n = state_q == S_RUN;
  assign busy = state_q != S_IDLE;
  assign done = state_q == S_DONE;
  assign timeout = timeout_q;
  assign no_instruct = len_q;
  assign imem_we = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller: scoreboard-based bench for the core run controller.
module tb_core_run_controller;
  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, in_valid = 0, eof = 0;
  logic [5:0] prog_len = 0;
  logic [31:0] in_data = 0;
  logic in_ready, imem_we, core_rst_n, busy, done, timeout;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [5:0] no_instruct;
  logic [15:0] cycle_count;
  int errors = 0, checks = 0, done_seen = 0;
  wr_t exp_q[$];

  core_run_controller dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .prog_len(prog_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
    .no_instruct(no_instruct), .eof(eof), .busy(busy), .done(done), .timeout(timeout),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_seen++;
    if (rst_n && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL imem_write unexpected addr=%0d data=%h", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (imem_addr !== e.a || imem_wdata !== e.d) begin
          errors++;
          $display("FAIL imem_write got addr=%0d data=%h want addr=%0d data=%h",
                   imem_addr, imem_wdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic load(input int len, input bit gaps, input int stop_after);
    prog_len = 6'(len);
    start = 1;
    tick();
    start = 0;
    chk("load_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < len && i < stop_after; i++) begin
      if (gaps) begin
        in_valid = 0;
        tick();
        chk("gap_in_ready", 32'(in_ready), 1);
      end
      in_valid = 1;
      in_data = $urandom;
      exp_q.push_back('{a: 8'(i * 4), d: in_data});
      tick();
    end
    in_valid = 0;
  endtask

  task automatic hold_to_run(input int len);
    chk("in_ready_after_last", 32'(in_ready), 0);
    chk("hold1_core_rst_n", 32'(core_rst_n), 0);
    chk("hold_no_instruct", 32'(no_instruct), 32'(len));
    tick();
    chk("hold2_core_rst_n", 32'(core_rst_n), 0);
    chk("hold2_no_instruct", 32'(no_instruct), 32'(len));
    tick();
    chk("run_core_rst_n", 32'(core_rst_n), 1);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
  endtask

  task automatic run_eof(input int n);
    for (int c = 1; c <= n; c++) begin
      eof = (c == n);
      tick();
    end
    eof = 0;
    chk("done_pulse", 32'(done), 1);
    chk("done_cycle_count", 32'(cycle_count), 32'(n));
    chk("done_timeout", 32'(timeout), 0);
    chk("done_core_rst_n", 32'(core_rst_n), 0);
    tick();
    chk("done_one_cycle", 32'(done), 0);
    chk("idle_after_done", 32'(busy), 0);
    chk("held_cycle_count", 32'(cycle_count), 32'(n));
  endtask

  task automatic test_reset();
    #3;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_imem_we", 32'(imem_we), 0);
    chk("rst_imem_addr", 32'(imem_addr), 0);
    chk("rst_imem_wdata", imem_wdata, 0);
    chk("rst_core_rst_n", 32'(core_rst_n), 0);
    chk("rst_no_instruct", 32'(no_instruct), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_cycle_count", 32'(cycle_count), 0);
    tick();
    rst_n = 1;
    tick();
  endtask

  task automatic test_basic();
    load(5, 0, 99);
    hold_to_run(5);
    run_eof(40);
  endtask

  task automatic test_gaps();
    load(5, 1, 99);
    hold_to_run(5);
    run_eof(3);
  endtask

  task automatic test_timeout();
    int d0;
    d0 = done_seen;
    load(2, 0, 99);
    hold_to_run(2);
    for (int c = 1; c < 1000; c++) tick();
    chk("pre_timeout_busy", 32'(busy), 1);
    chk("pre_timeout_flag", 32'(timeout), 0);
    tick();
    chk("timeout_flag", 32'(timeout), 1);
    chk("timeout_idle", 32'(busy), 0);
    chk("timeout_core_rst_n", 32'(core_rst_n), 0);
    chk("timeout_cycle_count", 32'(cycle_count), 1000);
    tick();
    chk("timeout_sticky", 32'(timeout), 1);
    chk("timeout_no_done", 32'(done_seen - d0), 0);
    load(1, 0, 99);
    chk("start_clears_timeout", 32'(timeout), 0);
    hold_to_run(1);
    run_eof(1);
  endtask

  task automatic test_eof_at_limit();
    load(3, 0, 99);
    hold_to_run(3);
    run_eof(1000);
  endtask

  task automatic test_abort();
    int d0;
    d0 = done_seen;
    load(4, 0, 2);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_load_idle", 32'(busy), 0);
    chk("abort_load_core_rst_n", 32'(core_rst_n), 0);
    chk("abort_load_in_ready", 32'(in_ready), 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    chk("abort_load_drained", 32'(exp_q.size()), 0);
    prog_len = 0;
    start = 1;
    tick();
    start = 0;
    chk("zero_len_ignored", 32'(busy), 0);
    load(2, 0, 99);
    hold_to_run(2);
    for (int c = 0; c < 5; c++) tick();
    prog_len = 7;
    start = 1;
    tick();
    start = 0;
    chk("busy_start_count", 32'(cycle_count), 6);
    chk("busy_start_no_instruct", 32'(no_instruct), 2);
    chk("busy_start_core_rst_n", 32'(core_rst_n), 1);
    abort = 1;
    tick();
    abort = 0;
    chk("abort_run_idle", 32'(busy), 0);
    chk("abort_run_core_rst_n", 32'(core_rst_n), 0);
    chk("abort_timeout_kept", 32'(timeout), 0);
    tick();
    chk("abort_no_done", 32'(done_seen - d0), 0);
  endtask

  task automatic test_async_reset();
    load(3, 0, 99);
    hold_to_run(3);
    for (int c = 0; c < 10; c++) tick();
    #2 rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_core_rst_n", 32'(core_rst_n), 0);
    chk("arst_cycle_count", 32'(cycle_count), 0);
    chk("arst_no_instruct", 32'(no_instruct), 0);
    chk("arst_imem", {imem_we, imem_addr}, 0);
    chk("arst_wdata", imem_wdata, 0);
    chk("arst_flags", {in_ready, done, timeout}, 0);
    @(negedge clk);
    rst_n = 1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_timeout();
    test_eof_at_limit();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
